// File: rtl/uart_tx_fifo.sv
// UART 8N1 transmitter with a small byte FIFO in front of it.
// Bytes arrive over a valid/ready handshake. They leave LSB first on a registered,
// idle-high serial line, and consecutive frames are sent with no idle gap.
module uart_tx_fifo #(
  parameter int CLKS_PER_BIT = 1250,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [7:0]                    i_tdat,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          tx,
  output logic                          o_busy,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt,
  output logic                          o_tx_done
);

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0] count_reg, count_next;
  logic [1:0]    state_reg, state_next;
  logic [BW-1:0] counter_reg;
  logic [2:0]    index_reg;
  logic [7:0]    shift_reg;
  logic          tx_reg, ready_reg, busy_reg, done_reg;
  logic          push, pop, counter_end;

  assign push        = i_valid && ready_reg;
  assign counter_end = (counter_reg == BW'(CLKS_PER_BIT - 1));

  // Next-state logic; a pop happens exactly when a new frame is loaded
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (count_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        if (counter_end) state_next = DATA;
      end
      DATA: begin
        if (counter_end && index_reg == 3'd7) state_next = STOP;
      end
      STOP: begin
        if (counter_end) begin
          if (count_reg != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FIFO occupancy after this edge's push and pop
  always_comb begin
    count_next = count_reg;
    if (push && !pop)
      count_next = count_reg + CW'(1);
    else if (!push && pop)
      count_next = count_reg - CW'(1);
  end

  // FIFO storage and pointers; reset flushes every entry
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ready_reg  <= 1'b1;
    end else begin
      if (push) begin
        mem[wr_ptr_reg] <= i_tdat;
        wr_ptr_reg      <= wr_ptr_reg + AW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ready_reg <= (count_next < CW'(FIFO_DEPTH));
    end
  end

  // Serialiser: state, bit timing, shift register and registered line outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg   <= IDLE;
      counter_reg <= '0;
      index_reg   <= '0;
      shift_reg   <= '0;
      tx_reg      <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (state_reg == IDLE || counter_end)
        counter_reg <= '0;
      else
        counter_reg <= counter_reg + BW'(1);

      if (pop)
        shift_reg <= mem[rd_ptr_reg];
      else if (state_reg == DATA && counter_end)
        shift_reg <= {1'b0, shift_reg[7:1]};

      if (state_reg == START && counter_end)
        index_reg <= '0;
      else if (state_reg == DATA && counter_end)
        index_reg <= index_reg + 3'd1;

      // The line follows the current state, so it lags the state by one clock
      case (state_reg)
        START:   tx_reg <= 1'b0;
        DATA:    tx_reg <= shift_reg[0];
        default: tx_reg <= 1'b1;
      endcase

      done_reg <= (state_reg == STOP) && counter_end;
      busy_reg <= (state_next != IDLE) || (count_next != '0);
    end
  end

  assign o_ready    = ready_reg;
  assign tx         = tx_reg;
  assign o_busy     = busy_reg;
  assign o_fifo_cnt = count_reg;
  assign o_tx_done  = done_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed testbench for uart_tx_fifo at 16 clocks per bit with a 4-entry FIFO.
module tb_uart_tx_fifo;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] i_tdat = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready, tx, o_busy, o_tx_done;
  logic [2:0] o_fifo_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  uart_tx_fifo #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clock      (clock),
    .reset      (reset),
    .i_tdat     (i_tdat),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .tx         (tx),
    .o_busy     (o_busy),
    .o_fifo_cnt (o_fifo_cnt),
    .o_tx_done  (o_tx_done)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold a byte on the handshake until an edge sees valid && ready
  task automatic push_hs(input logic [7:0] b);
    logic rdy;
    int   n;
    bit   acc;
    n = 0;
    acc = 1'b0;
    i_tdat = b;
    i_valid = 1'b1;
    while (!acc && n < 200) begin
      rdy = o_ready;
      tick();
      acc = rdy;
      n++;
    end
    i_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_%h: accepted=%0d required=1 within 200 cycles", b, acc);
    end
  endtask

  // Called on the first start-bit sample; leaves on the first sample after the frame
  task automatic check_frame(input logic [7:0] b);
    logic [9:0] fr;
    logic       exp_bit;
    int         bad_tx, bad_done;
    logic       bad_tx_val, bad_done_val;
    fr = {1'b1, b, 1'b0};
    bad_tx = -1;
    bad_done = -1;
    bad_tx_val = 1'b0;
    bad_done_val = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      exp_bit = fr[i / CPB];
      if (tx !== exp_bit && bad_tx < 0) begin
        bad_tx = i;
        bad_tx_val = tx;
      end
      if (o_tx_done !== (i == FRAME - 1) && bad_done < 0) begin
        bad_done = i;
        bad_done_val = o_tx_done;
      end
      tick();
    end
    checks++;
    if (bad_tx >= 0) begin
      errors++;
      $display("FAIL frame_%h_tx: clock %0d of frame tx=%b required=%b", b, bad_tx, bad_tx_val, fr[bad_tx / CPB]);
    end
    checks++;
    if (bad_done >= 0) begin
      errors++;
      $display("FAIL frame_%h_done: clock %0d of frame o_tx_done=%b required=%b", b, bad_done, bad_done_val, bad_done == FRAME - 1);
    end
  endtask

  task automatic wait_fall(output bit ok);
    int n;
    n = 0;
    while (tx !== 1'b0 && n < 50) begin
      tick();
      n++;
    end
    ok = (tx === 1'b0);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL start_bit_wait: tx=%b required=0 within 50 cycles", tx);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    i_valid = 1'b1;
    i_tdat = 8'h77;
    repeat (3) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b required 1", tx); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b required 1", o_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", o_busy); end
    checks++; if (o_fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_cnt: got %0d required 0", o_fifo_cnt); end
    checks++; if (o_tx_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b required 0", o_tx_done); end
    i_valid = 1'b0;
    reset = 1'b0;
    repeat (4) tick();
    checks++; if (o_fifo_cnt !== 3'd0) begin errors++; $display("FAIL reset_nothing_accepted_cnt: got %0d required 0", o_fifo_cnt); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL reset_nothing_sent_tx: got %b required 1", tx); end
  endtask

  task automatic test_single();
    i_tdat = 8'hA5;
    i_valid = 1'b1;
    tick();
    i_valid = 1'b0;
    checks++; if (o_fifo_cnt !== 3'd1) begin errors++; $display("FAIL single_cnt_after_push: got %0d required 1", o_fifo_cnt); end
    checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL single_busy_after_push: got %b required 1", o_busy); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_after_push: got %b required 1", tx); end
    tick();
    checks++; if (o_fifo_cnt !== 3'd0) begin errors++; $display("FAIL single_cnt_after_pop: got %0d required 0", o_fifo_cnt); end
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_at_pop: got %b required 1", tx); end
    tick();
    check_frame(8'hA5);
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL single_tx_idle: got %b required 1", tx); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b required 0", o_busy); end
  endtask

  task automatic test_back_to_back();
    int quiet_bad;
    fork
      begin
        for (int i = 0; i < 5; i++) push_hs(8'(i + 1));
        checks++; if (o_fifo_cnt !== 3'd4) begin errors++; $display("FAIL burst_cnt_full: got %0d required 4", o_fifo_cnt); end
        checks++; if (o_ready !== 1'b0) begin errors++; $display("FAIL burst_ready_full: got %b required 0", o_ready); end
        i_tdat = 8'hFF;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        checks++; if (o_fifo_cnt !== 3'd4) begin errors++; $display("FAIL full_push_ignored_cnt: got %0d required 4", o_fifo_cnt); end
      end
      begin
        bit ok;
        wait_fall(ok);
        if (ok) begin
          for (int f = 0; f < 5; f++) begin
            if (f > 0) begin
              checks++;
              if (tx !== 1'b0) begin errors++; $display("FAIL gap_before_frame_%0d: tx=%b required 0", f + 1, tx); end
            end
            check_frame(8'(f + 1));
          end
        end
        checks++; if (tx !== 1'b1) begin errors++; $display("FAIL burst_tx_idle: got %b required 1", tx); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL burst_busy_end: got %b required 0", o_busy); end
        checks++; if (o_fifo_cnt !== 3'd0) begin errors++; $display("FAIL burst_cnt_end: got %0d required 0", o_fifo_cnt); end
      end
    join
    quiet_bad = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (tx !== 1'b1 || o_tx_done !== 1'b0) quiet_bad++;
      tick();
    end
    checks++; if (quiet_bad != 0) begin errors++; $display("FAIL no_ff_frame: active cycles=%0d required 0", quiet_bad); end
  endtask

  task automatic test_reset_midframe();
    int quiet_bad;
    push_hs(8'h3C);
    push_hs(8'h11);
    push_hs(8'h22);
    checks++; if (o_fifo_cnt !== 3'd2) begin errors++; $display("FAIL midreset_queued_cnt: got %0d required 2", o_fifo_cnt); end
    checks++; if (tx !== 1'b0) begin errors++; $display("FAIL midreset_start_bit: got %b required 0", tx); end
    repeat (70) tick();
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_data_bit3: got %b required 1", tx); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (tx !== 1'b1) begin errors++; $display("FAIL midreset_tx: got %b required 1", tx); end
    checks++; if (o_fifo_cnt !== 3'd0) begin errors++; $display("FAIL midreset_cnt: got %0d required 0", o_fifo_cnt); end
    checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready: got %b required 1", o_ready); end
    checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b required 0", o_busy); end
    quiet_bad = 0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      tick();
      if (tx !== 1'b1 || o_tx_done !== 1'b0 || o_fifo_cnt !== 3'd0) quiet_bad++;
    end
    checks++; if (quiet_bad != 0) begin errors++; $display("FAIL midreset_no_frames: active cycles=%0d required 0", quiet_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
